// File: rtl/ifu_pcgen_pkg.sv
// ifu_pcgen_pkg -- shared definitions for the instruction-fetch PC generator.
//   DEF_PC_SIZE  : default fetch/PC width
//   DEF_XLEN     : integer register width of the core
//   DEF_RESET_PC : default first fetch address after reset
//   INSTR_W      : fetched instruction word width
//   OPC_*        : major opcodes recognised by the static predictor
//   pcgen_state_e: fetch FSM states
package ifu_pcgen_pkg;

   localparam int unsigned DEF_PC_SIZE  = 32;
   localparam int unsigned DEF_XLEN     = 32;
   localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
   localparam int unsigned INSTR_W      = 32;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      StReq  = 2'd0,
      StWait = 2'd1,
      StHold = 2'd2
   } pcgen_state_e;

endpackage

// File: rtl/ifu_litebpu.sv
// ifu_litebpu -- combinational static branch predictor.
//   JAL is always taken; a conditional branch is taken when its offset is negative
//   (backward loop); everything else falls through to pc + 4.
// Ports:
//   pc     in  PC_SIZE  address of the instruction
//   instr  in  32       instruction word
//   taken  out 1        predicted taken
//   target out PC_SIZE  predicted next pc (pc + 4 when not taken)
module ifu_litebpu
   import ifu_pcgen_pkg::*;
#(
   parameter int unsigned PC_SIZE = DEF_PC_SIZE
) (
   input  logic [PC_SIZE-1:0] pc,
   input  logic [INSTR_W-1:0] instr,
   output logic               taken,
   output logic [PC_SIZE-1:0] target
);

   logic [20:0] j_imm;
   logic [12:0] b_imm;
   logic        is_jal;
   logic        is_br;

   always_comb begin
      j_imm  = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      b_imm  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      is_jal = (instr[6:0] == OPC_JAL);
      is_br  = (instr[6:0] == OPC_BRANCH);
      taken  = is_jal | (is_br & b_imm[12]);
      if (is_jal) begin
         target = pc + {{(PC_SIZE-21){j_imm[20]}}, j_imm};
      end else if (taken) begin
         target = pc + {{(PC_SIZE-13){b_imm[12]}}, b_imm};
      end else begin
         target = pc + PC_SIZE'(4);
      end
   end

endmodule

// File: rtl/ifu_pcgen.sv
// ifu_pcgen -- single-outstanding instruction fetch PC generator.
//   REQ issues a fetch at pc_q, WAIT waits for the response, HOLD presents the
//   fetched word to decode until accepted. A branch-mispredict flush always wins
//   over the sequential/predicted pc; a response belonging to a flushed (or
//   pre-reset) fetch is swallowed via kill_q.
// Optional feature: define IFU_STATIC_BPU_EN to enable the static predictor
//   (ifu_litebpu); otherwise prediction is always not-taken and next pc = pc + 4.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   brchmis_flush_req/ack         redirect request from EXU; ack tied high
//   brchmis_flush_add_op1/op2     redirect target = op1 + op2
//   ifu_req_valid/ready, _pc      fetch request handshake and address
//   ifu_rsp_valid, ifu_rsp_instr  fetch response
//   ifu_o_valid/ready             handshake to decode
//   ifu_o_pc, ifu_o_ir            pc and word handed to decode
//   ifu_o_prdt_taken              prediction travelling with the instruction
module ifu_pcgen
   import ifu_pcgen_pkg::*;
#(
   parameter int unsigned        PC_SIZE  = DEF_PC_SIZE,
   parameter logic [PC_SIZE-1:0] RESET_PC = PC_SIZE'(DEF_RESET_PC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               brchmis_flush_req,
   output logic               brchmis_flush_ack,
   input  logic [PC_SIZE-1:0] brchmis_flush_add_op1,
   input  logic [PC_SIZE-1:0] brchmis_flush_add_op2,
   output logic               ifu_req_valid,
   input  logic               ifu_req_ready,
   output logic [PC_SIZE-1:0] ifu_req_pc,
   input  logic               ifu_rsp_valid,
   input  logic [INSTR_W-1:0] ifu_rsp_instr,
   output logic               ifu_o_valid,
   input  logic               ifu_o_ready,
   output logic [PC_SIZE-1:0] ifu_o_pc,
   output logic [INSTR_W-1:0] ifu_o_ir,
   output logic               ifu_o_prdt_taken
);

   pcgen_state_e       state_q, state_d;
   logic [PC_SIZE-1:0] pc_q, pc_d;
   logic               kill_q, kill_d;
   logic [PC_SIZE-1:0] o_pc_q, o_pc_d;
   logic [INSTR_W-1:0] o_ir_q, o_ir_d;
   logic               o_prdt_q, o_prdt_d;

   logic [PC_SIZE-1:0] flush_pc;
   logic [PC_SIZE-1:0] next_pc;
   logic               prdt_taken;

   assign brchmis_flush_ack = 1'b1;
   assign flush_pc          = brchmis_flush_add_op1 + brchmis_flush_add_op2;

   // In WAIT pc_q is still the address of the outstanding fetch, so the
   // prediction is formed from pc_q and the incoming word.
`ifdef IFU_STATIC_BPU_EN
   ifu_litebpu #(
      .PC_SIZE (PC_SIZE)
   ) u_litebpu (
      .pc     (pc_q),
      .instr  (ifu_rsp_instr),
      .taken  (prdt_taken),
      .target (next_pc)
   );
`else
   assign prdt_taken = 1'b0;
   assign next_pc    = pc_q + PC_SIZE'(4);
`endif

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      kill_d        = kill_q;
      o_pc_d        = o_pc_q;
      o_ir_d        = o_ir_q;
      o_prdt_d      = o_prdt_q;
      ifu_req_valid = 1'b0;

      unique case (state_q)
         StReq: begin
            // No request goes out while reset is held.
            ifu_req_valid = ~rst;
            // A response seen here can only be the stale one from before reset.
            if (kill_q && ifu_rsp_valid) begin
               kill_d = 1'b0;
            end
            if (ifu_req_valid && ifu_req_ready) begin
               state_d = StWait;
               // Request leaves with the old pc; its response must be dropped.
               if (brchmis_flush_req) begin
                  kill_d = 1'b1;
               end
            end
            if (brchmis_flush_req) begin
               pc_d = flush_pc;
            end
         end

         StWait: begin
            if (ifu_rsp_valid) begin
               if (kill_q || brchmis_flush_req) begin
                  kill_d  = 1'b0;
                  state_d = StReq;
               end else begin
                  o_pc_d   = pc_q;
                  o_ir_d   = ifu_rsp_instr;
                  o_prdt_d = prdt_taken;
                  pc_d     = next_pc;
                  state_d  = StHold;
               end
            end else if (brchmis_flush_req) begin
               kill_d = 1'b1;
            end
            if (brchmis_flush_req) begin
               pc_d = flush_pc;
            end
         end

         StHold: begin
            // With o_ready the word is delivered even if a flush arrives too.
            if (ifu_o_ready || brchmis_flush_req) begin
               state_d = StReq;
            end
            if (brchmis_flush_req) begin
               pc_d = flush_pc;
            end
         end

         default: begin
            state_d = StReq;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StReq;
         pc_q     <= RESET_PC;
         // A fetch in flight across reset still owes a response; swallow it.
         kill_q   <= (kill_q | (state_q == StWait)) & ~ifu_rsp_valid;
         o_pc_q   <= '0;
         o_ir_q   <= '0;
         o_prdt_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         kill_q   <= kill_d;
         o_pc_q   <= o_pc_d;
         o_ir_q   <= o_ir_d;
         o_prdt_q <= o_prdt_d;
      end
   end

   assign ifu_req_pc       = pc_q;
   assign ifu_o_valid      = (state_q == StHold);
   assign ifu_o_pc         = o_pc_q;
   assign ifu_o_ir         = o_ir_q;
   assign ifu_o_prdt_taken = o_prdt_q;

endmodule

// File: tb/tb_ifu_pcgen.sv
// tb_ifu_pcgen -- self-checking bench for ifu_pcgen: directed sequences, a vector
// table of redirect/prediction cases, and a randomized run against a
// transaction-level reference model.
module tb_ifu_pcgen;

   logic        clk;
   logic        rst;
   logic        brchmis_flush_req;
   logic        brchmis_flush_ack;
   logic [31:0] brchmis_flush_add_op1;
   logic [31:0] brchmis_flush_add_op2;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [31:0] ifu_req_pc;
   logic        ifu_rsp_valid;
   logic [31:0] ifu_rsp_instr;
   logic        ifu_o_valid;
   logic        ifu_o_ready;
   logic [31:0] ifu_o_pc;
   logic [31:0] ifu_o_ir;
   logic        ifu_o_prdt_taken;

   int n_chk = 0;
   int n_err = 0;

`ifdef IFU_STATIC_BPU_EN
   localparam bit BPU = 1'b1;
`else
   localparam bit BPU = 1'b0;
`endif

   localparam logic [31:0] NOP = 32'h0000_0013;

   ifu_pcgen u_dut (
      .clk                   (clk),
      .rst                   (rst),
      .brchmis_flush_req     (brchmis_flush_req),
      .brchmis_flush_ack     (brchmis_flush_ack),
      .brchmis_flush_add_op1 (brchmis_flush_add_op1),
      .brchmis_flush_add_op2 (brchmis_flush_add_op2),
      .ifu_req_valid         (ifu_req_valid),
      .ifu_req_ready         (ifu_req_ready),
      .ifu_req_pc            (ifu_req_pc),
      .ifu_rsp_valid         (ifu_rsp_valid),
      .ifu_rsp_instr         (ifu_rsp_instr),
      .ifu_o_valid           (ifu_o_valid),
      .ifu_o_ready           (ifu_o_ready),
      .ifu_o_pc              (ifu_o_pc),
      .ifu_o_ir              (ifu_o_ir),
      .ifu_o_prdt_taken      (ifu_o_prdt_taken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference prediction from the instruction-set rules, using integer offsets.
   function automatic int ref_jimm(input logic [31:0] i);
      int v;
      v = int'(i[30:21]) * 2 + int'(i[20]) * 2048 + int'(i[19:12]) * 4096;
      if (i[31]) v = v - 1048576;
      return v;
   endfunction

   function automatic int ref_bimm(input logic [31:0] i);
      int v;
      v = int'(i[11:8]) * 2 + int'(i[30:25]) * 32 + int'(i[7]) * 2048;
      if (i[31]) v = v - 4096;
      return v;
   endfunction

   function automatic logic ref_taken(input logic [31:0] i);
      logic t;
      t = 1'b0;
`ifdef IFU_STATIC_BPU_EN
      if (i[6:0] == 7'h6F) t = 1'b1;
      else if (i[6:0] == 7'h63 && ref_bimm(i) < 0) t = 1'b1;
`endif
      return t;
   endfunction

   function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] i);
      logic [31:0] n;
      n = pc + 32'd4;
      if (ref_taken(i)) begin
         if (i[6:0] == 7'h6F) n = pc + 32'(ref_jimm(i));
         else                 n = pc + 32'(ref_bimm(i));
      end
      return n;
   endfunction

   typedef struct {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] instr;
      logic [31:0] exp_pc;
      logic        exp_taken;
      logic [31:0] exp_next;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ir;
      logic        taken;
   } out_t;

   vec_t        tbl [6];
   logic [31:0] pool [6];
   out_t        q [$];
   out_t        item;
   logic [31:0] m_pc;
   logic        m_pend;
   logic        m_live;
   logic        exp_v;
   logic        exp_r;

   initial begin
      rst                   = 1'b1;
      brchmis_flush_req     = 1'b0;
      brchmis_flush_add_op1 = '0;
      brchmis_flush_add_op2 = '0;
      ifu_req_ready         = 1'b0;
      ifu_rsp_valid         = 1'b0;
      ifu_rsp_instr         = '0;
      ifu_o_ready           = 1'b0;

      tbl[0] = '{32'h8000_0000, 32'h0000_0100, 32'hFE00_0EE3, 32'h8000_0100, BPU,
                 BPU ? 32'h8000_00FC : 32'h8000_0104};
      tbl[1] = '{32'hFFFF_FFF0, 32'h0000_000C, NOP, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000};
      tbl[2] = '{32'h8000_0000, 32'h0000_0200, 32'h0080_006F, 32'h8000_0200, BPU,
                 BPU ? 32'h8000_0208 : 32'h8000_0204};
      tbl[3] = '{32'h8000_0300, 32'h0000_0000, 32'h0000_0463, 32'h8000_0300, 1'b0,
                 32'h8000_0304};
      tbl[4] = '{32'h7FFF_FC00, 32'h0000_0800, 32'hFF1F_F06F, 32'h8000_0400, BPU,
                 BPU ? 32'h8000_03F0 : 32'h8000_0404};
      tbl[5] = '{32'h8000_0000, 32'h8000_0200, NOP, 32'h0000_0200, 1'b0, 32'h0000_0204};

      pool[0] = NOP;
      pool[1] = 32'hFE00_0EE3;
      pool[2] = 32'h0080_006F;
      pool[3] = 32'h0000_0463;
      pool[4] = 32'hFF1F_F06F;
      pool[5] = 32'h1234_5678;

      // Reset values and the flush ack during reset.
      tick();
      settle();
      chk("rst flush_ack", 32'(brchmis_flush_ack), 32'd1);
      chk("rst req_valid", 32'(ifu_req_valid), 32'd0);
      tick();
      chk("rst o_valid", 32'(ifu_o_valid), 32'd0);
      chk("rst o_pc", ifu_o_pc, 32'h0);
      chk("rst o_ir", ifu_o_ir, 32'h0);
      chk("rst o_prdt", 32'(ifu_o_prdt_taken), 32'd0);

      // Straight-line fetch of three NOPs.
      rst           = 1'b0;
      ifu_req_ready = 1'b1;
      ifu_o_ready   = 1'b1;
      settle();
      for (int k = 0; k < 3; k++) begin
         chk("seq req_valid", 32'(ifu_req_valid), 32'd1);
         chk("seq req_pc", ifu_req_pc, 32'h8000_0000 + 32'(4 * k));
         tick();
         ifu_rsp_valid = 1'b1;
         ifu_rsp_instr = NOP;
         tick();
         ifu_rsp_valid = 1'b0;
         settle();
         chk("seq o_valid", 32'(ifu_o_valid), 32'd1);
         chk("seq o_pc", ifu_o_pc, 32'h8000_0000 + 32'(4 * k));
         tick();
      end
      ifu_req_ready = 1'b0;
      ifu_o_ready   = 1'b0;

      // Flush while waiting: pending word dropped, fetch at op1 + op2.
      ifu_req_ready = 1'b1;
      tick();
      ifu_req_ready         = 1'b0;
      brchmis_flush_req     = 1'b1;
      brchmis_flush_add_op1 = 32'h8000_0010;
      brchmis_flush_add_op2 = 32'h0000_0020;
      tick();
      brchmis_flush_req = 1'b0;
      settle();
      chk("wflush req_valid", 32'(ifu_req_valid), 32'd0);
      ifu_rsp_valid = 1'b1;
      ifu_rsp_instr = NOP;
      tick();
      ifu_rsp_valid = 1'b0;
      settle();
      chk("wflush o_valid", 32'(ifu_o_valid), 32'd0);
      chk("wflush req_valid2", 32'(ifu_req_valid), 32'd1);
      chk("wflush req_pc", ifu_req_pc, 32'h8000_0030);

      // Decode stalls in HOLD, then a flush.
      ifu_req_ready = 1'b1;
      tick();
      ifu_req_ready = 1'b0;
      ifu_rsp_valid = 1'b1;
      ifu_rsp_instr = 32'h0010_0093;
      tick();
      ifu_rsp_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         settle();
         chk("hold o_valid", 32'(ifu_o_valid), 32'd1);
         chk("hold o_pc", ifu_o_pc, 32'h8000_0030);
         chk("hold o_ir", ifu_o_ir, 32'h0010_0093);
         chk("hold req_valid", 32'(ifu_req_valid), 32'd0);
         tick();
      end
      brchmis_flush_req     = 1'b1;
      brchmis_flush_add_op1 = 32'h9000_0000;
      brchmis_flush_add_op2 = 32'h0000_0040;
      tick();
      brchmis_flush_req = 1'b0;
      settle();
      chk("hflush o_valid", 32'(ifu_o_valid), 32'd0);
      chk("hflush req_valid", 32'(ifu_req_valid), 32'd1);
      chk("hflush req_pc", ifu_req_pc, 32'h9000_0040);

      // Vector table: redirect, fetch, check prediction and following request.
      for (int v = 0; v < 6; v++) begin
         brchmis_flush_req     = 1'b1;
         brchmis_flush_add_op1 = tbl[v].op1;
         brchmis_flush_add_op2 = tbl[v].op2;
         tick();
         brchmis_flush_req = 1'b0;
         ifu_req_ready     = 1'b1;
         settle();
         chk("tbl req_pc", ifu_req_pc, tbl[v].exp_pc);
         tick();
         ifu_req_ready = 1'b0;
         ifu_rsp_valid = 1'b1;
         ifu_rsp_instr = tbl[v].instr;
         tick();
         ifu_rsp_valid = 1'b0;
         settle();
         chk("tbl o_valid", 32'(ifu_o_valid), 32'd1);
         chk("tbl o_pc", ifu_o_pc, tbl[v].exp_pc);
         chk("tbl o_ir", ifu_o_ir, tbl[v].instr);
         chk("tbl o_prdt", 32'(ifu_o_prdt_taken), 32'(tbl[v].exp_taken));
         ifu_o_ready = 1'b1;
         tick();
         ifu_o_ready = 1'b0;
         settle();
         chk("tbl next req_valid", 32'(ifu_req_valid), 32'd1);
         chk("tbl next req_pc", ifu_req_pc, tbl[v].exp_next);
      end

      // Reset while a fetch is outstanding; stale response two cycles later.
      ifu_req_ready = 1'b1;
      tick();
      ifu_req_ready = 1'b0;
      rst           = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      chk("rstw req_valid", 32'(ifu_req_valid), 32'd1);
      chk("rstw req_pc", ifu_req_pc, 32'h8000_0000);
      tick();
      ifu_rsp_valid = 1'b1;
      ifu_rsp_instr = 32'hDEAD_BEEF;
      tick();
      ifu_rsp_valid = 1'b0;
      settle();
      chk("rstw stale o_valid", 32'(ifu_o_valid), 32'd0);
      chk("rstw req_pc2", ifu_req_pc, 32'h8000_0000);
      ifu_req_ready = 1'b1;
      tick();
      ifu_req_ready = 1'b0;
      ifu_rsp_valid = 1'b1;
      ifu_rsp_instr = NOP;
      tick();
      ifu_rsp_valid = 1'b0;
      settle();
      chk("rstw o_valid", 32'(ifu_o_valid), 32'd1);
      chk("rstw o_pc", ifu_o_pc, 32'h8000_0000);

      // Randomized traffic against the transaction-level model.
      rst = 1'b1;
      tick();
      tick();
      rst    = 1'b0;
      m_pc   = 32'h8000_0000;
      m_pend = 1'b0;
      m_live = 1'b0;
      q.delete();
      for (int c = 0; c < 1500; c++) begin
         ifu_req_ready         = 1'($urandom_range(0, 1));
         ifu_rsp_valid         = m_pend && ($urandom_range(0, 2) == 0);
         ifu_rsp_instr         = pool[$urandom_range(0, 5)];
         ifu_o_ready           = ($urandom_range(0, 3) != 0);
         brchmis_flush_req     = ($urandom_range(0, 9) == 0);
         brchmis_flush_add_op1 = $urandom();
         brchmis_flush_add_op2 = $urandom();
         settle();

         exp_v = (q.size() != 0);
         chk("rnd o_valid", 32'(ifu_o_valid), 32'(exp_v));
         if (exp_v) begin
            chk("rnd o_pc", ifu_o_pc, q[0].pc);
            chk("rnd o_ir", ifu_o_ir, q[0].ir);
            chk("rnd o_prdt", 32'(ifu_o_prdt_taken), 32'(q[0].taken));
         end
         exp_r = !m_pend && !exp_v;
         chk("rnd req_valid", 32'(ifu_req_valid), 32'(exp_r));
         if (exp_r) chk("rnd req_pc", ifu_req_pc, m_pc);
         chk("rnd flush_ack", 32'(brchmis_flush_ack), 32'd1);

         if (exp_v && (ifu_o_ready || brchmis_flush_req)) void'(q.pop_front());
         if (ifu_rsp_valid) begin
            if (m_live && !brchmis_flush_req) begin
               item.pc    = m_pc;
               item.ir    = ifu_rsp_instr;
               item.taken = ref_taken(ifu_rsp_instr);
               q.push_back(item);
               m_pc = ref_next(m_pc, ifu_rsp_instr);
            end
            m_pend = 1'b0;
         end
         if (exp_r && ifu_req_ready) begin
            m_pend = 1'b1;
            m_live = !brchmis_flush_req;
         end else if (m_pend && brchmis_flush_req) begin
            m_live = 1'b0;
         end
         if (brchmis_flush_req) m_pc = brchmis_flush_add_op1 + brchmis_flush_add_op2;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ifu_pcgen.md
IFU_PCGEN -- requirements
Module: ifu_pcgen

Interface
REQ-001 Parameter PC_SIZE, default `PC_SIZE, fetch/PC width.
REQ-002 Parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 brchmis_flush_req  input  1  branch-mispredict redirect request from EXU.
REQ-006 brchmis_flush_ack  output  1  flush accept; tied to 1.
REQ-007 brchmis_flush_add_op1/op2  input  PC_SIZE each  redirect target operands; target = op1 + op2.
REQ-008 ifu_req_valid/ifu_req_ready  output/input  1  instruction-fetch request handshake.
REQ-009 ifu_req_pc  output  PC_SIZE  fetch address.
REQ-010 ifu_rsp_valid  input  1  fetch response; ifu_rsp_instr  input  32  fetched word.
REQ-011 ifu_o_valid/ifu_o_ready  output/input  1  handshake to decode.
REQ-012 ifu_o_pc  output  PC_SIZE; ifu_o_ir  output  32; ifu_o_prdt_taken  output  1  prediction sent down the pipe with the instruction.

Function
REQ-013 At most one fetch shall be outstanding; FSM states: REQ, WAIT, HOLD.
REQ-014 REQ: ifu_req_valid=1, ifu_req_pc=pc_r; on handshake -> WAIT.
REQ-015 WAIT: on ifu_rsp_valid, capture pc/instr/prediction into the output register, raise ifu_o_valid, compute next pc -> HOLD.
REQ-016 HOLD: ifu_o_valid=1, outputs stable; on ifu_o_ready -> REQ in the next cycle; latency is 1 cycle from response to ifu_o_valid and 1 cycle from decode handshake to the next request.
REQ-017 Next pc = pc + 4 unless predicted taken (REQ-027), modulo 2^PC_SIZE (wrap silently).
REQ-018 brchmis_flush_ack shall be 1 in every cycle, including during reset.
REQ-019 Flush in REQ: pc_r <= op1+op2; request in the same cycle keeps the old pc; a request handshaked in that cycle is treated as killed (REQ-020).
REQ-020 Flush in WAIT: set kill_r; the matching response is consumed and discarded; kill_r clears on that response; state -> REQ with the new pc.
REQ-021 Flush in HOLD: ifu_o_valid drops next cycle, buffered instruction discarded, -> REQ with the new pc.
REQ-022 Flush in the same cycle as ifu_rsp_valid in WAIT: response discarded, flush target wins.
REQ-023 Flush in the same cycle as the decode handshake: instruction counts as delivered; next fetch uses the flush target.
REQ-024 Flush shall always take priority over the sequential/predicted next pc.
REQ-025 ifu_o_valid shall never assert for a killed response.

Reset
REQ-026 On rst: pc_r=RESET_PC, state=REQ, kill_r=0, ifu_o_valid=0, ifu_o_pc=0, ifu_o_ir=0, ifu_o_prdt_taken=0; the first request is issued in the cycle after rst deasserts; rst mid-fetch discards any later response for the old fetch via kill_r=1 held until the first response after reset.

Configuration
REQ-027 With IFU_STATIC_BPU_EN defined: JAL (opcode 1101111) is predicted taken with next pc = pc + J-imm; B-type (opcode 1100011) with negative B-imm is predicted taken with next pc = pc + B-imm; all other instructions are predicted not-taken.
REQ-028 Without IFU_STATIC_BPU_EN: ifu_o_prdt_taken=0 always; next pc = pc + 4.

Structure
REQ-029 PC_SIZE, XLEN, RESET_PC default and opcode constants shall live in the shared defines file.
REQ-030 Prediction shall be a combinational sub-module ifu_litebpu (inputs pc, instr; outputs taken, target), instantiated only under IFU_STATIC_BPU_EN.

Verification
REQ-031 Reset, req_ready=1, rsp with NOPs, o_ready=1 -> request PCs 0x80000000, 0x80000004, 0x80000008.
REQ-032 Flush with op1=0x80000010, op2=0x20 during WAIT -> pending response dropped, next request pc=0x80000030, no ifu_o_valid for the dropped word.
REQ-033 o_ready=0 for 5 cycles in HOLD -> ifu_o_* stable, no new request; then flush -> o_valid falls, fetch at the target.
REQ-034 BPU on: instr 0xFE000EE3 (beq x0,x0,-4) at 0x80000100 -> prdt_taken=1, next pc 0x800000FC; BPU off -> prdt_taken=0, next pc 0x80000104.
REQ-035 rst asserted in WAIT, stale rsp arrives 2 cycles later -> rsp ignored, fetch restarts at 0x80000000.
REQ-036 pc=0xFFFFFFFC, sequential -> next request pc=0x00000000.
